// File: rtl/flash_voice_arbiter_pkg.sv
// Shared types and defaults for the flash voice arbiter slice.
// Holds the FSM state enum and the pointer-wrap helper.
package flash_arb_pkg;

  localparam int FL_WAIT_DEFAULT = 4;
  localparam int FL_ADDR_W       = 22;
  localparam int MAX_VOICES      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_LO = 2'd1,
    RD_HI = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

  // Advance a voice index by one, wrapping back to 0 after the last voice.
  function automatic logic [2:0] wrap_inc(input logic [2:0] idx, input int num_voices);
    if (int'(idx) >= num_voices - 1) return 3'd0;
    return idx + 3'd1;
  endfunction

endpackage

// File: rtl/flash_voice_arbiter_if.sv
// Voice-side bus between the per-voice sample players and the flash arbiter.
interface flash_voice_arbiter_if
  import flash_arb_pkg::*;
#(
  parameter int NUM_VOICES = 7,
  parameter int ADDR_W     = FL_ADDR_W
);

  logic [NUM_VOICES-1:0]        i_req;
  logic [NUM_VOICES*ADDR_W-1:0] i_addr;
  logic [NUM_VOICES-1:0]        i_mask;
  logic [NUM_VOICES-1:0]        o_ack;
  logic [15:0]                  o_data;
  logic                         o_busy;
  logic [2:0]                   o_gnt_id;

  modport master (
    output i_req, i_addr, i_mask,
    input  o_ack, o_data, o_busy, o_gnt_id
  );

  modport slave (
    input  i_req, i_addr, i_mask,
    output o_ack, o_data, o_busy, o_gnt_id
  );

endinterface

// File: rtl/flash_voice_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible voice at or after ptr,
// searching upward modulo NUM_VOICES.
module rr_pick
  import flash_arb_pkg::*;
#(
  parameter int NUM_VOICES = 7
) (
  input  logic [NUM_VOICES-1:0] elig,
  input  logic [2:0]            ptr,
  output logic                  found,
  output logic [2:0]            idx
);

  int k;

  // Scan from the farthest offset down so the nearest eligible voice wins last.
  always_comb begin
    found = 1'b0;
    idx   = 3'd0;
    k     = 0;
    for (int off = NUM_VOICES - 1; off >= 0; off--) begin
      k = int'(ptr) + off;
      if (k >= NUM_VOICES) k = k - NUM_VOICES;
      if (elig[k[2:0]]) begin
        found = 1'b1;
        idx   = k[2:0];
      end
    end
  end

endmodule

// File: rtl/flash_voice_arbiter.sv
// Shares one 8-bit sample flash between several note voices: round-robin pick,
// two timed byte reads, then a one-cycle ack carrying the 16-bit sample.
module flash_voice_arbiter
  import flash_arb_pkg::*;
#(
  parameter int NUM_VOICES  = 7,
  parameter int ADDR_W      = FL_ADDR_W,
  parameter int WAIT_CYCLES = FL_WAIT_DEFAULT
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  flash_voice_arbiter_if.slave  bus,
  output logic [ADDR_W-1:0]     o_fl_addr,
  output logic                  o_fl_ce_n,
  output logic                  o_fl_oe_n,
  output logic                  o_fl_we_n,
  output logic                  o_fl_rst_n,
  input  logic [7:0]            i_fl_dq
);

  localparam logic [3:0] LAST_WAIT = 4'(WAIT_CYCLES - 1);

  arb_state_t              state;
  logic [3:0]              wait_cnt;
  logic [2:0]              ptr;
  logic [ADDR_W-1:0]       addr_r;
  logic [7:0]              lo_r;

  logic [NUM_VOICES-1:0]   elig;
  logic                    pick_found;
  logic [2:0]              pick_idx;
  logic [ADDR_W-1:0]       pick_addr;

  assign elig      = bus.i_req & bus.i_mask;
  assign pick_addr = bus.i_addr[pick_idx*ADDR_W +: ADDR_W];

  // The flash is only ever read, so write enable and reset stay parked high.
  assign o_fl_we_n  = 1'b1;
  assign o_fl_rst_n = 1'b1;

  rr_pick #(
    .NUM_VOICES(NUM_VOICES)
  ) u_pick (
    .elig  (elig),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Outputs are loaded on the edge entering each state so pins are clean registers.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state        <= IDLE;
      wait_cnt     <= 4'd0;
      ptr          <= 3'd0;
      addr_r       <= '0;
      lo_r         <= 8'd0;
      bus.o_ack    <= '0;
      bus.o_data   <= 16'd0;
      bus.o_busy   <= 1'b0;
      bus.o_gnt_id <= 3'd0;
      o_fl_addr    <= '0;
      o_fl_ce_n    <= 1'b1;
      o_fl_oe_n    <= 1'b1;
    end else begin
      bus.o_ack <= '0;
      unique case (state)
        IDLE: begin
          if (pick_found) begin
            addr_r       <= pick_addr;
            bus.o_gnt_id <= pick_idx;
            o_fl_addr    <= pick_addr;
            o_fl_ce_n    <= 1'b0;
            o_fl_oe_n    <= 1'b0;
            bus.o_busy   <= 1'b1;
            wait_cnt     <= 4'd0;
            state        <= RD_LO;
          end
        end
        RD_LO: begin
          if (wait_cnt == LAST_WAIT) begin
            lo_r      <= i_fl_dq;
            wait_cnt  <= 4'd0;
            o_fl_addr <= addr_r + 1'b1;
            state     <= RD_HI;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        RD_HI: begin
          if (wait_cnt == LAST_WAIT) begin
            bus.o_data <= {i_fl_dq, lo_r};
            bus.o_ack  <= NUM_VOICES'(1) << bus.o_gnt_id;
            wait_cnt   <= 4'd0;
            o_fl_ce_n  <= 1'b1;
            o_fl_oe_n  <= 1'b1;
            state      <= ACK;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ACK: begin
          ptr        <= wrap_inc(bus.o_gnt_id, NUM_VOICES);
          bus.o_busy <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/flash_voice_arbiter.md
# flash_voice_arbiter

Shares the single 8-bit audio sample flash between up to seven note voices, so several notes can sound in one beat instead of one enable word at a time. Each voice presents a byte address and a request. The arbiter picks voices round-robin, runs two timed flash byte reads, and returns an assembled 16-bit sample with a one-cycle acknowledge. It sits between the per-voice sample players (fed by the note-enable word) and the flash pins.

## Interface
- NUM_VOICES, 7, number of requesters; 1..8 supported.
- ADDR_W, 22, flash byte-address width.
- WAIT_CYCLES, 4, iCLK cycles per flash byte read; at 50 MHz this covers 70 ns access. Legal range 2..15.

Reset iRST, asynchronous, active-low; clock iCLK.
- iCLK  in  1  system clock
- iRST  in  1  asynchronous active-low reset
- i_req  in  NUM_VOICES  per-voice request; level, held until that voice's o_ack
- i_addr  in  NUM_VOICES*ADDR_W  per-voice low-byte address; voice k occupies bits [k*ADDR_W +: ADDR_W]
- i_mask  in  NUM_VOICES  voice enable; a request with mask 0 is ignored
- o_ack  out  NUM_VOICES  one-hot, one-cycle pulse: sample for that voice is valid
- o_data  out  16  assembled sample {hi byte, lo byte}; valid only while o_ack != 0
- o_busy  out  1  transaction in progress (state != IDLE)
- o_gnt_id  out  3  index of the voice being served or last served
- o_fl_addr  out  ADDR_W  flash address
- o_fl_ce_n  out  1  flash chip enable, active low
- o_fl_oe_n  out  1  flash output enable, active low
- o_fl_we_n  out  1  constant 1 (read-only use)
- o_fl_rst_n  out  1  constant 1
- i_fl_dq  in  8  flash data

## Operation
- Eligible set E = i_req & i_mask.
- States: IDLE, RD_LO, RD_HI, ACK.
- IDLE
  - If E != 0: pick the first eligible index at or after ptr, searching upward modulo NUM_VOICES.
  - Latch that voice's address into addr_r and its index into o_gnt_id. Go to RD_LO and clear wait_cnt.
  - If E == 0: stay in IDLE with ce_n/oe_n = 1.
- RD_LO
  - o_fl_addr = addr_r; ce_n = oe_n = 0; wait_cnt increments.
  - On wait_cnt == WAIT_CYCLES-1: capture i_fl_dq into lo byte, clear wait_cnt, go to RD_HI.
- RD_HI
  - o_fl_addr = addr_r + 1, wrapping modulo 2^ADDR_W (all-ones wraps to 0).
  - Same wait rule; the capture goes into the hi byte. Then go to ACK.
- ACK
  - o_ack[o_gnt_id] = 1 and o_data = {hi, lo}.
  - ptr = o_gnt_id+1, wrapping to 0 after NUM_VOICES-1. Go to IDLE.
- ce_n/oe_n return to 1 in ACK and IDLE.
- Requester rules:
  - Dropping i_req or changing i_addr mid-transaction does not abort it: the latched address is used and the ack still pulses.
  - A requester still holding i_req after its ack is treated as a new request.
  - Mask changes affect only future picks.

## Timing
- All outputs are registered.
- Reset values:
  - o_ack = 0, o_data = 0, o_busy = 0, o_gnt_id = 0.
  - o_fl_addr = 0, o_fl_ce_n = 1, o_fl_oe_n = 1.
  - o_fl_we_n = 1, o_fl_rst_n = 1.
  - ptr = 0, state = IDLE.
- Grant in IDLE at cycle T:
  - RD_LO occupies T+1..T+W; lo byte captured at the end of T+W.
  - RD_HI occupies T+W+1..T+2W; hi byte captured at the end of T+2W.
  - ACK at T+2W+1; next grant possible at T+2W+2.
- Latency from grant to ack is 2W+1 cycles (9 with W=4). Throughput is one sample per 2W+2 cycles.
- i_req arriving in the same cycle as an ACK is evaluated in the following IDLE cycle.
- Reset asserted mid-read: immediate return to reset values. No ack is issued; the requester must re-request.
- Starvation bound: any eligible voice is served within NUM_VOICES transactions.

## Structure
- Package flash_arb_pkg holds:
  - state enum {IDLE, RD_LO, RD_HI, ACK};
  - defaults FL_WAIT_DEFAULT = 4 and FL_ADDR_W = 22;
  - MAX_VOICES = 8.
- Sub-module rr_pick (combinational): inputs E and ptr; outputs a found flag and an index. Use it once in IDLE.
- Remaining logic is the FSM, the wait counter, the address/byte registers and the pin drivers.

## Test plan
- **Single voice:** voice 2 requests addr 0x000100 with flash bytes 0x34@0x100 and 0x12@0x101 -> o_ack=0000100 at T+9, o_data=0x1234, o_fl_addr 0x100 then 0x101.
- **Round-robin:** voices 0, 3 and 6 request continuously from reset -> ack order 0,3,6,0,3,6, each 10 cycles apart.
- **Mask:** voices 1 and 4 request with i_mask[1]=0 -> only voice 4 is acked. Set mask[1]=1 -> voice 1 is acked next.
- **Address wrap:** addr 0x3FFFFF -> second read at 0x000000; o_data = {byte@0, byte@0x3FFFFF}.
- **Mid-transaction drop:** voice 5 deasserts i_req and changes i_addr during RD_LO -> the original address is read and o_ack[5] still pulses.
- **Reset mid-RD_HI:** assert iRST -> all outputs take reset values immediately, no ack. After release a pending request is re-served, starting from ptr 0.
